baud_gen_frac: RTL
==================

# baud_gen_frac

Parametrised fractional baud-rate generator for the UART datapath; the successor to the fixed-table integer baud divider. It produces a 1-cycle oversample tick for the RX sampler, a 1-cycle bit tick for the TX shifter, and a 50 %-duty `baud_clk` level. Divisors carry a fractional part, so the average rate is exact to 1/2^FRAC_W clock. Rate changes are applied glitch-free on bit boundaries through a load/ack handshake.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency; used only to derive the preset divisors.
- `OVS`, default 16: oversample ticks per bit; must be even and ≥ 4.
- `INT_W`, default 16: integer bits of the divisor.
- `FRAC_W`, default 4: fractional bits of the divisor.
- `clock`, in, 1: system clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `en`, in, 1: run enable.
- `rate_sel`, in, 3: 0..3 select the 2400/4800/9600/19200 presets; 4 selects `div_custom`; 5..7 are reserved and cause `cfg_err`.
- `div_custom`, in, INT_W+FRAC_W: clocks per oversample tick, unsigned fixed point with FRAC_W fractional bits.
- `cfg_load`, in, 1: 1-cycle pulse that captures `rate_sel`/`div_custom`.
- `cfg_ack`, out, 1: 1-cycle pulse in the cycle the pending configuration becomes active.
- `cfg_err`, out, 1: 1-cycle pulse, the cycle after a rejected `cfg_load`.
- `ovs_tick`, out, 1: 1-cycle oversample strobe.
- `bit_tick`, out, 1: 1-cycle strobe coincident with every OVS-th `ovs_tick`.
- `baud_clk`, out, 1: high while oversample index < OVS/2.
- `active_div`, out, INT_W+FRAC_W: the divisor currently in use.

## Operation
- ONE = 2^FRAC_W. Preset divisor = round(CLK_HZ·ONE / (baud·OVS)). At the defaults, 2400 baud gives 20833.
- Fractional accumulator `acc` (INT_W+FRAC_W bits). Each enabled cycle:
  - if acc+ONE ≥ div: assert `ovs_tick` and set acc ← acc+ONE−div;
  - otherwise acc ← acc+ONE.
  - Compute the sum one bit wider so it cannot overflow.
- Oversample index `oi`, range 0..OVS−1, increments on `ovs_tick` and wraps to 0. `bit_tick` = `ovs_tick` while oi = OVS−1.
- Config validation at `cfg_load`. Rejected if `rate_sel` is 5..7, or `rate_sel`=4 with `div_custom` < 2·ONE. A rejected load:
  - pulses `cfg_err`;
  - leaves the pending and active divisors unchanged;
  - produces no `cfg_ack`.
- A valid load stores the resolved divisor as pending.
  - A second valid load before apply overwrites pending; only one `cfg_ack` is issued.
  - Apply happens in the cycle of the next `bit_tick`: the new divisor is used from the following cycle, `acc` and `oi` wrap normally, and `cfg_ack` is asserted coincident with that `bit_tick`.
  - If `en`=0, the load is applied on the next cycle: `cfg_ack` is asserted one cycle after `cfg_load`.
- `en`=0:
  - `acc` and `oi` are held at 0;
  - `ovs_tick`, `bit_tick` and `baud_clk` are 0;
  - pending configuration is still accepted and applied.
- Reset:
  - `acc`=0, `oi`=0, active divisor = preset 0, no pending configuration;
  - all 1-bit outputs 0, `active_div` = preset 0.
  - Reset mid-bit discards any pending configuration; no `cfg_ack` is issued.

## Timing
- All outputs are registered and take effect on the rising edge of `clock`.
- First `ovs_tick` comes ceil(div/ONE) cycles after the first edge with `en`=1. Preset 0 at the defaults: 1303.
- Tick spacing is floor or ceil of div/ONE cycles. The long-run average is exactly div/ONE; error does not accumulate.
- `bit_tick` period: over any OVS ticks, the sum is within ±1 cycle of OVS·div/ONE. At the defaults this is 20833 ± 1.
- `cfg_err` is 1 cycle after `cfg_load`. `cfg_ack` is at most one bit period plus 1 cycle after `cfg_load`.
- Simultaneous `cfg_load` and `bit_tick`: the load is captured and applied at the next `bit_tick`, not the current one.

## Structure
- Package `baud_pkg` holds:
  - the `rate_sel` encoding constants;
  - the preset baud list;
  - the function `preset_div(CLK_HZ, OVS, FRAC_W, idx)`;
  - the MIN_DIV constant (= 2·ONE).
- Sub-module `baud_frac_acc`: the accumulator and compare. Inputs: `en`, `div`. Output: `ovs_tick`.
- The top level holds `oi`, the config handshake, and output registering.

## Test plan
- Defaults, `en`=1 after reset → first `ovs_tick` at cycle 1303. The 16 ticks sum to 20833±1 cycles, with exactly one `bit_tick`. `baud_clk` is high for `oi` 0..7.
- `rate_sel`=4, `div_custom`=32, `en`=0 → `cfg_ack` next cycle. Then with `en`=1: `ovs_tick` every 2 cycles, `bit_tick` every 32.
- `div_custom`=31 with `rate_sel`=4, and separately `rate_sel`=6 → `cfg_err` pulse each time, no `cfg_ack`, `active_div` stays 20833.
- Running at 2400, `cfg_load` `rate_sel`=3 mid-bit → old spacing continues until `bit_tick`, `cfg_ack` coincident with it, then `active_div`=2604 and spacing 162/163.
- Two valid loads (1, then 2) within one bit → a single `cfg_ack`, and `active_div`=5208.
- Assert `rst` mid-bit with a load pending → all outputs 0 immediately. After release, no `cfg_ack` and `active_div`=20833. Deassert `en` mid-bit → ticks stop next cycle and `oi` restarts at 0.

Source files
------------

// File: rtl/baud_gen_frac_pkg.sv
//------------------------------------------------------------------------------
// Module   : baud_pkg
// Purpose  : Rate-select encoding, preset baud list and divisor helpers for
//            the fractional baud-rate generator.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package baud_pkg;

    localparam logic [2:0] c_RATE_2400   = 3'd0;
    localparam logic [2:0] c_RATE_4800   = 3'd1;
    localparam logic [2:0] c_RATE_9600   = 3'd2;
    localparam logic [2:0] c_RATE_19200  = 3'd3;
    localparam logic [2:0] c_RATE_CUSTOM = 3'd4;

    localparam int unsigned c_NUM_PRESETS = 4;
    localparam int unsigned c_PRESET_BAUD [c_NUM_PRESETS] = '{2400, 4800, 9600, 19200};

    // Smallest legal divisor, in units of ONE; keeps ticks at least 2 cycles apart.
    localparam int unsigned c_MIN_DIV_ONES = 2;

    // round(clk_hz * 2^frac_w / (baud * ovs))
    function automatic longint unsigned preset_div(
        input longint unsigned clk_hz,
        input int unsigned     ovs,
        input int unsigned     frac_w,
        input logic [1:0]      idx
    );
        longint unsigned num;
        longint unsigned den;
        num = clk_hz << frac_w;
        den = 64'(c_PRESET_BAUD[idx]) * 64'(ovs);
        return (num + den / 64'd2) / den;
    endfunction

    function automatic longint unsigned min_div(input int unsigned frac_w);
        return 64'(c_MIN_DIV_ONES) << frac_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/baud_gen_frac_if.sv
//------------------------------------------------------------------------------
// Module   : baud_gen_frac_if
// Purpose  : Configuration handshake and tick outputs of the baud generator.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface baud_gen_frac_if #(
    parameter int unsigned INT_W  = 16,
    parameter int unsigned FRAC_W = 4
);
    logic                    en;
    logic [2:0]              rate_sel;
    logic [INT_W+FRAC_W-1:0] div_custom;
    logic                    cfg_load;
    logic                    cfg_ack;
    logic                    cfg_err;
    logic                    ovs_tick;
    logic                    bit_tick;
    logic                    baud_clk;
    logic [INT_W+FRAC_W-1:0] active_div;

    modport master (
        output en, rate_sel, div_custom, cfg_load,
        input  cfg_ack, cfg_err, ovs_tick, bit_tick, baud_clk, active_div
    );

    modport slave (
        input  en, rate_sel, div_custom, cfg_load,
        output cfg_ack, cfg_err, ovs_tick, bit_tick, baud_clk, active_div
    );
endinterface

`default_nettype wire

// File: rtl/baud_gen_frac_acc.sv
//------------------------------------------------------------------------------
// Module   : baud_frac_acc
// Purpose  : Fractional phase accumulator; flags the cycle whose edge yields
//            an oversample tick.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module baud_frac_acc #(
    parameter int unsigned INT_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    en,
    input  logic [INT_W+FRAC_W-1:0] div,
    output logic                    ovs_tick
);
    localparam int unsigned DW = INT_W + FRAC_W;
    localparam logic [DW:0] c_ONE = {{DW{1'b0}}, 1'b1} << FRAC_W;

    logic [DW-1:0] r_acc;
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_wrap;

    // One extra bit so acc+ONE never wraps before the compare.
    assign w_sum    = {1'b0, r_acc} + c_ONE;
    assign ovs_tick = en && (w_sum >= {1'b0, div});
    // Remainder is below ONE, so modulo-2^DW subtraction is exact.
    assign w_wrap   = w_sum[DW-1:0] - div;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (!en) begin
            r_acc <= '0;
        end else if (ovs_tick) begin
            r_acc <= w_wrap;
        end else begin
            r_acc <= w_sum[DW-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/baud_gen_frac.sv
//------------------------------------------------------------------------------
// Module   : baud_gen_frac
// Purpose  : Fractional baud-rate generator with oversample/bit ticks, baud
//            clock and glitch-free rate changes on bit boundaries.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module baud_gen_frac
    import baud_pkg::*;
#(
    parameter longint unsigned CLK_HZ = 64'd50_000_000,
    parameter int unsigned     OVS    = 16,
    parameter int unsigned     INT_W  = 16,
    parameter int unsigned     FRAC_W = 4
) (
    input  logic           clock,
    input  logic           rst,
    baud_gen_frac_if.slave bus
);
    localparam int unsigned DW   = INT_W + FRAC_W;
    localparam int unsigned OI_W = $clog2(OVS);

    localparam logic [OI_W-1:0] c_OI_LAST = OI_W'(OVS - 1);
    localparam logic [OI_W-1:0] c_OI_HALF = OI_W'(OVS / 2);
    localparam logic [DW-1:0]   c_MIN_DIV = DW'(min_div(FRAC_W));
    localparam logic [DW-1:0]   c_PRESET0 = DW'(preset_div(CLK_HZ, OVS, FRAC_W, 2'd0));
    localparam logic [DW-1:0]   c_PRESET1 = DW'(preset_div(CLK_HZ, OVS, FRAC_W, 2'd1));
    localparam logic [DW-1:0]   c_PRESET2 = DW'(preset_div(CLK_HZ, OVS, FRAC_W, 2'd2));
    localparam logic [DW-1:0]   c_PRESET3 = DW'(preset_div(CLK_HZ, OVS, FRAC_W, 2'd3));

    logic [DW-1:0]   r_active_div;
    logic [DW-1:0]   r_pend_div;
    logic            r_pend_valid;
    logic [OI_W-1:0] r_oi;
    logic            r_ovs_tick;
    logic            r_bit_tick;
    logic            r_baud_clk;
    logic            r_cfg_ack;
    logic            r_cfg_err;

    logic [DW-1:0]   w_new_div;
    logic            w_valid;
    logic            w_load_ok;
    logic            w_load_bad;
    logic            w_hit;
    logic            w_bit_hit;
    logic [OI_W-1:0] w_oi_next;

    always_comb begin
        w_new_div = c_PRESET0;
        w_valid   = 1'b1;
        case (bus.rate_sel)
            c_RATE_2400:   w_new_div = c_PRESET0;
            c_RATE_4800:   w_new_div = c_PRESET1;
            c_RATE_9600:   w_new_div = c_PRESET2;
            c_RATE_19200:  w_new_div = c_PRESET3;
            c_RATE_CUSTOM: begin
                w_new_div = bus.div_custom;
                w_valid   = (bus.div_custom >= c_MIN_DIV);
            end
            default:       w_valid = 1'b0;
        endcase
        w_load_ok  = bus.cfg_load && w_valid;
        w_load_bad = bus.cfg_load && !w_valid;
    end

    baud_frac_acc #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_acc (
        .clock    (clock),
        .rst      (rst),
        .en       (bus.en),
        .div      (r_active_div),
        .ovs_tick (w_hit)
    );

    assign w_bit_hit = w_hit && (r_oi == c_OI_LAST);

    always_comb begin
        w_oi_next = r_oi;
        if (!bus.en) begin
            w_oi_next = '0;
        end else if (w_bit_hit) begin
            w_oi_next = '0;
        end else if (w_hit) begin
            w_oi_next = r_oi + OI_W'(1);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_active_div <= c_PRESET0;
            r_pend_div   <= c_PRESET0;
            r_pend_valid <= 1'b0;
            r_oi         <= '0;
            r_ovs_tick   <= 1'b0;
            r_bit_tick   <= 1'b0;
            r_baud_clk   <= 1'b0;
            r_cfg_ack    <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_oi       <= w_oi_next;
            r_ovs_tick <= w_hit;
            r_bit_tick <= w_bit_hit;
            r_baud_clk <= bus.en && (w_oi_next < c_OI_HALF);
            r_cfg_err  <= w_load_bad;
            r_cfg_ack  <= 1'b0;
            if (!bus.en) begin
                // Stopped: there is no bit boundary to wait for.
                if (w_load_ok) begin
                    r_active_div <= w_new_div;
                    r_cfg_ack    <= 1'b1;
                    r_pend_valid <= 1'b0;
                end else if (r_pend_valid) begin
                    r_active_div <= r_pend_div;
                    r_cfg_ack    <= 1'b1;
                    r_pend_valid <= 1'b0;
                end
            end else begin
                if (w_bit_hit && r_pend_valid) begin
                    r_active_div <= r_pend_div;
                    r_cfg_ack    <= 1'b1;
                    r_pend_valid <= 1'b0;
                end
                // A load coinciding with the apply edge waits for the next bit.
                if (w_load_ok) begin
                    r_pend_div   <= w_new_div;
                    r_pend_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.ovs_tick   = r_ovs_tick;
    assign bus.bit_tick   = r_bit_tick;
    assign bus.baud_clk   = r_baud_clk;
    assign bus.cfg_ack    = r_cfg_ack;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.active_div = r_active_div;

endmodule

`default_nettype wire
